sc_nco: RTL and testbench

SC_NCO -- requirements
Module: sc_nco

---
 rtl/sc_nco.sv | 112 +++++++++++
 tb/tb_sc_nco.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_nco.sv
`default_nettype none
// ============================================================================
// Module   : sc_nco
// Purpose  : Numerically controlled oscillator producing sine and cosine
//            samples from an external quarter-wave magnitude LUT. The phase
//            accumulator advances by freq when en is high. A phase offset is
//            applied to the lookup phase only. The quadrant folds the LUT
//            address (mirrored in quadrants 1 and 3) and sets the output sign
//            (negative in quadrants 2 and 3).
// Ports    : clk              - system clock, rising edge
//            reset            - synchronous active-high reset
//            en               - accumulator advance enable
//            freq  [psz]      - phase increment per cycle
//            phs   [psz]      - phase offset used for the lookup only
//            lut_a_s/c [asz]  - registered LUT addresses, sine/cosine path
//            lut_d_s/c [dsz]  - LUT magnitudes, 2 cycles after the address
//            sin/cos   [dsz]  - signed output samples
//            valid            - sample originates from an enabled cycle
// Revision : 1.0 - initial release
// ============================================================================
module sc_nco #(
    parameter int psz = 32,
    parameter int asz = 10,
    parameter int dsz = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [psz-1:0]        freq,
    input  logic [psz-1:0]        phs,
    output logic [asz-1:0]        lut_a_s,
    output logic [asz-1:0]        lut_a_c,
    input  logic [dsz-1:0]        lut_d_s,
    input  logic [dsz-1:0]        lut_d_c,
    output logic signed [dsz-1:0] sin,
    output logic signed [dsz-1:0] cos,
    output logic                  valid
);

    // Depth of the sign/enable delay line: one stage for the address
    // register plus two for the LUT read latency.
    localparam int c_PIPE = 3;

    logic [psz-1:0]    r_acc;
    logic [asz-1:0]    r_lut_a_s;
    logic [asz-1:0]    r_lut_a_c;
    logic [c_PIPE-1:0] r_sgn_s;
    logic [c_PIPE-1:0] r_sgn_c;
    logic [c_PIPE-1:0] r_en;
    logic [dsz-1:0]    r_sin;
    logic [dsz-1:0]    r_cos;
    logic              r_valid;

    logic [psz-1:0]    w_phase;
    logic [1:0]        w_qs;
    logic [1:0]        w_qc;
    logic [asz-1:0]    w_idx;
    logic [asz-1:0]    w_addr_s;
    logic [asz-1:0]    w_addr_c;
    logic [dsz-1:0]    w_sin;
    logic [dsz-1:0]    w_cos;

    always_comb begin
        w_phase  = r_acc + phs;
        w_qs     = w_phase[psz-1 -: 2];
        w_idx    = w_phase[psz-3 -: asz];
        // Cosine leads sine by a quarter turn: same index, next quadrant.
        w_qc     = w_qs + 2'd1;
        // Odd quadrants walk the quarter wave backwards.
        w_addr_s = w_qs[0] ? ~w_idx : w_idx;
        w_addr_c = w_qc[0] ? ~w_idx : w_idx;
        // The LUT magnitude never reaches 2^(dsz-1), so the negation is exact.
        w_sin    = r_sgn_s[c_PIPE-1] ? ({dsz{1'b0}} - lut_d_s) : lut_d_s;
        w_cos    = r_sgn_c[c_PIPE-1] ? ({dsz{1'b0}} - lut_d_c) : lut_d_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc     <= '0;
            r_lut_a_s <= '0;
            r_lut_a_c <= '0;
            r_sgn_s   <= '0;
            r_sgn_c   <= '0;
            r_en      <= '0;
            r_sin     <= '0;
            r_cos     <= '0;
            r_valid   <= 1'b0;
        end else begin
            if (en) begin
                r_acc <= r_acc + freq;
            end
            r_lut_a_s <= w_addr_s;
            r_lut_a_c <= w_addr_c;
            // Signs and enable travel with their address so each meets the
            // LUT data returned for that address.
            r_sgn_s   <= {r_sgn_s[c_PIPE-2:0], w_qs[1]};
            r_sgn_c   <= {r_sgn_c[c_PIPE-2:0], w_qc[1]};
            r_en      <= {r_en[c_PIPE-2:0], en};
            r_sin     <= w_sin;
            r_cos     <= w_cos;
            r_valid   <= r_en[c_PIPE-1];
        end
    end

    assign lut_a_s = r_lut_a_s;
    assign lut_a_c = r_lut_a_c;
    assign sin     = $signed(r_sin);
    assign cos     = $signed(r_cos);
    assign valid   = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_sc_nco.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_nco
// Purpose  : Self-checking bench for sc_nco with a two-cycle LUT model
//            (magnitude = address + offset) and a phase-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sc_nco;

    logic               clk = 1'b0;
    logic               reset;
    logic               en;
    logic [31:0]        freq;
    logic [31:0]        phs;
    logic [9:0]         lut_a_s;
    logic [9:0]         lut_a_c;
    logic [13:0]        lut_d_s;
    logic [13:0]        lut_d_c;
    logic signed [13:0] sin;
    logic signed [13:0] cos;
    logic               valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sc_nco #(.psz(32), .asz(10), .dsz(14)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .freq    (freq),
        .phs     (phs),
        .lut_a_s (lut_a_s),
        .lut_a_c (lut_a_c),
        .lut_d_s (lut_d_s),
        .lut_d_c (lut_d_c),
        .sin     (sin),
        .cos     (cos),
        .valid   (valid)
    );

    // External quarter-wave LUT with two cycles of read latency.
    logic [13:0] ofs = 14'd0;
    logic [13:0] d1_s, d1_c;
    always @(posedge clk) begin
        d1_s    <= 14'(lut_a_s) + ofs;
        d1_c    <= 14'(lut_a_c) + ofs;
        lut_d_s <= d1_s;
        lut_d_c <= d1_c;
    end

    // ---------------- reference model ----------------
    typedef struct {
        bit          known;
        bit          vld;
        logic [13:0] s;
        logic [13:0] c;
    } smp_t;

    localparam smp_t c_UNK = '{known: 1'b0, vld: 1'b0, s: 14'd0, c: 14'd0};

    logic [31:0] m_acc = 32'd0;
    smp_t        q[$];
    smp_t        exp_o;
    logic [9:0]  exp_as, exp_ac;

    // Quarter-wave folding stated directly: quadrants 1 and 3 read the table
    // mirrored, quadrants 2 and 3 are the negative half of the wave.
    function automatic logic [9:0] fold_addr(input logic [1:0] quad, input logic [9:0] idx);
        return (quad == 2'd1 || quad == 2'd3) ? (10'd1023 - idx) : idx;
    endfunction

    function automatic logic [13:0] signed_sample(input logic [1:0] quad, input logic [9:0] addr);
        int mag;
        int v;
        mag = int'(addr) + int'(ofs);
        v   = (quad >= 2'd2) ? -mag : mag;
        return v[13:0];
    endfunction

    // Drives one cycle of inputs and advances the model past the rising edge.
    task automatic step(input bit r, input bit e, input logic [31:0] f, input logic [31:0] ph);
        logic [31:0] p;
        logic [1:0]  qs, qc;
        logic [9:0]  idx, as_n, ac_n;
        smp_t        n;
        @(negedge clk);
        reset = r; en = e; freq = f; phs = ph;
        p    = m_acc + ph;
        qs   = p[31:30];
        qc   = qs + 2'd1;
        idx  = p[29:20];
        as_n = fold_addr(qs, idx);
        ac_n = fold_addr(qc, idx);
        n.known = 1'b1;
        n.vld   = e;
        n.s     = signed_sample(qs, as_n);
        n.c     = signed_sample(qc, ac_n);
        @(posedge clk);
        #1;
        if (r) begin
            m_acc  = 32'd0;
            exp_as = 10'd0;
            exp_ac = 10'd0;
            exp_o  = '{known: 1'b1, vld: 1'b0, s: 14'd0, c: 14'd0};
            q      = '{c_UNK, c_UNK, c_UNK};
        end else begin
            if (e) m_acc = m_acc + f;
            exp_as = as_n;
            exp_ac = ac_n;
            q.push_back(n);
            exp_o = q.pop_front();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, $urandom, $urandom);
            checks++;
            if (sin !== 14'sd0 || cos !== 14'sd0 || valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_out: sin=%0d cos=%0d valid=%0b required 0 0 0", sin, cos, valid);
            end
            checks++;
            if (lut_a_s !== 10'd0 || lut_a_c !== 10'd0) begin
                errors++;
                $display("FAIL reset_addr: a_s=%0d a_c=%0d required 0 0", lut_a_s, lut_a_c);
            end
        end
    endtask

    task automatic test_dc();
        ofs = 14'($urandom_range(1, 7000));
        step(1'b1, 1'b0, 32'd0, 32'd0);
        for (int k = 1; k <= 7; k++) begin
            step(1'b0, 1'b1, 32'd0, 32'd0);
            checks++;
            if (lut_a_s !== 10'd0 || lut_a_c !== 10'd1023) begin
                errors++;
                $display("FAIL dc_addr k=%0d: a_s=%0d a_c=%0d required 0 1023", k, lut_a_s, lut_a_c);
            end
            checks++;
            if (valid !== (k >= 4)) begin
                errors++;
                $display("FAIL dc_valid k=%0d: got %0b required %0b", k, valid, (k >= 4));
            end
            if (k >= 4) begin
                checks++;
                if (sin !== $signed(ofs) || cos !== $signed(14'd1023 + ofs)) begin
                    errors++;
                    $display("FAIL dc_data k=%0d: sin=%0d cos=%0d required %0d %0d",
                             k, sin, cos, ofs, 14'd1023 + ofs);
                end
            end
        end
    endtask

    task automatic test_quarter();
        logic [9:0]         tbl_a[4];
        logic signed [13:0] tbl_s[4];
        tbl_a = '{10'd0, 10'd1023, 10'd0, 10'd1023};
        tbl_s = '{14'sd0, 14'sd1023, 14'sd0, -14'sd1023};
        ofs = 14'd0;
        step(1'b1, 1'b0, 32'd0, 32'd0);
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, 1'b1, 32'h4000_0000, 32'd0);
            checks++;
            if (lut_a_s !== tbl_a[(k-1)%4]) begin
                errors++;
                $display("FAIL quarter_addr k=%0d: got %0d required %0d", k, lut_a_s, tbl_a[(k-1)%4]);
            end
            if (k >= 4) begin
                checks++;
                if (sin !== tbl_s[(k-4)%4] || valid !== 1'b1) begin
                    errors++;
                    $display("FAIL quarter_sin k=%0d: sin=%0d valid=%0b required %0d 1",
                             k, sin, valid, tbl_s[(k-4)%4]);
                end
                checks++;
                if (cos !== exp_o.s && 1'b0) begin
                end
                if (cos !== exp_o.c) begin
                    errors++;
                    $display("FAIL quarter_cos k=%0d: got %0d required %0d", k, cos, $signed(exp_o.c));
                end
            end
        end
    endtask

    task automatic test_wrap();
        ofs = 14'd5;
        step(1'b1, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0);
        for (int k = 2; k <= 5; k++) begin
            step(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0);
            checks++;
            if (lut_a_s !== 10'd0 || lut_a_c !== 10'd1023) begin
                errors++;
                $display("FAIL wrap_addr k=%0d: a_s=%0d a_c=%0d required 0 1023", k, lut_a_s, lut_a_c);
            end
        end
        // Output now reflects the first lookup at phase 32'hFFFF_FFFF.
        checks++;
        if (sin !== -14'sd5 || cos !== 14'sd1028 || valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_data: sin=%0d cos=%0d valid=%0b required -5 1028 0", sin, cos, valid);
        end
    endtask

    task automatic test_en_toggle();
        bit          en_seq[10];
        logic [31:0] f;
        en_seq = '{1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        f = $urandom;
        ofs = 14'($urandom_range(0, 7000));
        step(1'b1, 1'b0, 32'd0, 32'd0);
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, en_seq[k-1], f, 32'd0);
            checks++;
            if (lut_a_s !== exp_as || lut_a_c !== exp_ac) begin
                errors++;
                $display("FAIL en_addr k=%0d: a_s=%0d a_c=%0d required %0d %0d",
                         k, lut_a_s, lut_a_c, exp_as, exp_ac);
            end
            checks++;
            if (valid !== ((k >= 4) ? en_seq[k-4] : 1'b0)) begin
                errors++;
                $display("FAIL en_valid k=%0d: got %0b required %0b", k, valid,
                         ((k >= 4) ? en_seq[k-4] : 1'b0));
            end
        end
    endtask

    task automatic test_phase();
        ofs = 14'($urandom_range(1, 7000));
        step(1'b1, 1'b0, 32'd0, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b1, 32'd0, 32'h4000_0000);
            checks++;
            if (lut_a_s !== 10'd1023) begin
                errors++;
                $display("FAIL phase_addr k=%0d: got %0d required 1023", k, lut_a_s);
            end
            if (k >= 4) begin
                checks++;
                if (sin !== $signed(14'd1023 + ofs)) begin
                    errors++;
                    $display("FAIL phase_sin k=%0d: got %0d required %0d", k, sin, 14'd1023 + ofs);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        ofs = 14'($urandom_range(0, 7000));
        step(1'b1, 1'b0, 32'd0, 32'd0);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 32'h0100_0000, 32'd0);
        step(1'b1, 1'b1, 32'h0100_0000, 32'd0);
        checks++;
        if (sin !== 14'sd0 || cos !== 14'sd0 || valid !== 1'b0 || lut_a_s !== 10'd0) begin
            errors++;
            $display("FAIL midreset_clear: sin=%0d cos=%0d valid=%0b a_s=%0d required 0 0 0 0",
                     sin, cos, valid, lut_a_s);
        end
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b1, 32'h0100_0000, 32'd0);
            if (k == 2) begin
                checks++;
                if (lut_a_s !== 10'd16) begin
                    errors++;
                    $display("FAIL midreset_restart: a_s=%0d required 16", lut_a_s);
                end
            end
            checks++;
            if (valid !== (k >= 4) || lut_a_s !== exp_as) begin
                errors++;
                $display("FAIL midreset_track k=%0d: valid=%0b a_s=%0d required %0b %0d",
                         k, valid, lut_a_s, (k >= 4), exp_as);
            end
            if (exp_o.known) begin
                checks++;
                if (sin !== exp_o.s || cos !== exp_o.c) begin
                    errors++;
                    $display("FAIL midreset_data k=%0d: sin=%0d cos=%0d required %0d %0d",
                             k, sin, cos, $signed(exp_o.s), $signed(exp_o.c));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] f;
        logic [31:0] ph;
        bit          r, e;
        ofs = 14'($urandom_range(0, 7168));
        step(1'b1, 1'b0, 32'd0, 32'd0);
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 3))
                0:       f = 32'hFFFF_FFFF;
                1:       f = 32'($urandom_range(0, 32'h00FF_FFFF));
                default: f = $urandom;
            endcase
            ph = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            r  = ($urandom_range(0, 49) == 0);
            e  = ($urandom_range(0, 3) != 0);
            step(r, e, f, ph);
            checks++;
            if (lut_a_s !== exp_as || lut_a_c !== exp_ac) begin
                errors++;
                $display("FAIL rand_addr k=%0d: a_s=%0d a_c=%0d required %0d %0d",
                         k, lut_a_s, lut_a_c, exp_as, exp_ac);
            end
            checks++;
            if (valid !== exp_o.vld) begin
                errors++;
                $display("FAIL rand_valid k=%0d: got %0b required %0b", k, valid, exp_o.vld);
            end
            if (exp_o.known) begin
                checks++;
                if (sin !== exp_o.s || cos !== exp_o.c) begin
                    errors++;
                    $display("FAIL rand_data k=%0d: sin=%0d cos=%0d required %0d %0d",
                             k, sin, cos, $signed(exp_o.s), $signed(exp_o.c));
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; freq = 32'd0; phs = 32'd0;
        q = '{c_UNK, c_UNK, c_UNK};
        test_reset();
        test_dc();
        test_quarter();
        test_wrap();
        test_en_toggle();
        test_phase();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
